// File: rtl/shift_out.sv
// rtl/shift_out.sv - serial byte shifter driving an external shift-register chain (sclk/sdata/rclk)
// Optional build macro SHIFT_OUT_LSB_FIRST_EN: shift bit 0 first instead of bit 7.
module shift_out #(
    parameter int unsigned CLKDIV = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_load,
    input  logic       i_latch,
    output logic       o_busy,
    output logic       o_sdata,
    output logic       o_sclk,
    output logic       o_rclk
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LATCH    = 2'd1,
        SHIFT_LO = 2'd2,
        SHIFT_HI = 2'd3
    } state_t;

    localparam logic [7:0] PHASE_TC = 8'(CLKDIV - 1);

    state_t     state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] data_q, data_d;
    logic       pend_q, pend_d;
    logic       sdata_q, sdata_d;
    logic       busy_q;
    logic       phase_done;

    assign phase_done = (phase_q == PHASE_TC);

    function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] idx);
`ifdef SHIFT_OUT_LSB_FIRST_EN
        return b[idx];
`else
        return b[3'd7 - idx];
`endif
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            phase_q <= 8'd0;
            bit_q   <= 3'd0;
            data_q  <= 8'd0;
            pend_q  <= 1'b0;
            sdata_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            sdata_q <= sdata_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        data_d  = data_q;
        pend_d  = pend_q;
        sdata_d = sdata_q;
        case (state_q)
            IDLE: begin
                // A simultaneous load is dropped: the latch wins and the byte is lost.
                if (i_latch) begin
                    state_d = LATCH;
                    phase_d = 8'd0;
                end else if (i_load) begin
                    state_d = SHIFT_LO;
                    phase_d = 8'd0;
                    bit_d   = 3'd0;
                    data_d  = i_data;
                    sdata_d = pick_bit(i_data, 3'd0);
                end
            end
            LATCH: begin
                if (phase_done) begin
                    state_d = IDLE;
                    phase_d = 8'd0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            SHIFT_LO: begin
                if (i_latch) pend_d = 1'b1;
                if (phase_done) begin
                    state_d = SHIFT_HI;
                    phase_d = 8'd0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            SHIFT_HI: begin
                if (i_latch) pend_d = 1'b1;
                if (phase_done) begin
                    phase_d = 8'd0;
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        // A latch request arriving in the very last cycle is still honoured.
                        if (pend_q || i_latch) begin
                            state_d = LATCH;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = SHIFT_LO;
                        bit_d   = bit_q + 3'd1;
                        sdata_d = pick_bit(data_q, bit_q + 3'd1);
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy  = busy_q;
        o_sdata = sdata_q;
        o_sclk  = (state_q == SHIFT_HI);
        o_rclk  = (state_q == LATCH);
    end

endmodule

// File: doc/shift_out.md
SHIFT_OUT -- requirements
Module: shift_out

Interface
REQ-001 SHALL have parameter CLKDIV, default 2, the number of i_clk cycles in each o_sclk phase (low or high); legal range 1..255.
REQ-002 SHALL have port i_clk, input, 1, system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port i_data, input, 8, segment byte for one display digit; sampled only when a load is accepted.
REQ-005 SHALL have port i_load, input, 1, one-cycle load strobe from the display controller.
REQ-006 SHALL have port i_latch, input, 1, latch request; transfers the shifted chain to the driver outputs.
REQ-007 SHALL have port o_busy, output, 1, high while a shift or latch pulse is in progress or pending.
REQ-008 SHALL have port o_sdata, output, 1, serial data to the external shift-register chain.
REQ-009 SHALL have port o_sclk, output, 1, shift clock to the chain.
REQ-010 SHALL have port o_rclk, output, 1, storage/latch clock to the chain.

Function
REQ-011 SHALL implement the states IDLE, LATCH, SHIFT_LO, SHIFT_HI, with a CLKDIV-cycle phase counter and a 3-bit bit index.
REQ-012 SHALL accept i_load only in IDLE: it captures i_data and enters SHIFT_LO at bit index 0.
REQ-013 SHALL register o_busy and drive it high from the cycle after an accepted i_load or i_latch; it falls in the cycle the FSM re-enters IDLE.
REQ-014 SHALL ignore i_load while o_busy is high; the captured byte and the ongoing shift are unaffected.
REQ-015 SHALL hold o_sclk low in SHIFT_LO and high in SHIFT_HI, with each state lasting exactly CLKDIV cycles.
REQ-016 SHALL update o_sdata only on entry to SHIFT_LO, so it is stable for the whole SHIFT_HI phase and valid at the rising edge of o_sclk.
REQ-017 SHALL leave SHIFT_HI for SHIFT_LO with the bit index incremented; after bit 7, SHIFT_HI SHALL go to IDLE, or to LATCH if a latch is pending.
REQ-018 SHALL set o_busy high for exactly 16*CLKDIV cycles per byte when no latch is pending.
REQ-019 SHALL, on i_latch in IDLE, enter LATCH and hold o_rclk high for CLKDIV cycles, then return to IDLE; o_sclk SHALL remain low throughout.
REQ-020 SHALL record i_latch asserted while busy as a single pending flag (repeat requests do not accumulate) and serve it immediately after the current byte.
REQ-021 SHALL, when i_load and i_latch are both asserted in IDLE, perform LATCH first; the load is discarded and never shifted out.
REQ-022 SHALL hold o_sdata at its last value in IDLE and LATCH.
REQ-023 SHALL treat phase counter wrap as terminal count CLKDIV-1; CLKDIV=1 gives 1-cycle phases with no stall.

Reset
REQ-024 SHALL, while i_rst is high, force IDLE, o_busy=0, o_sdata=0, o_sclk=0, o_rclk=0, clear the pending latch, and zero the bit index and phase counter.
REQ-025 SHALL let i_rst abort a shift or latch pulse mid-operation with no further sclk or rclk edges; the first i_load accepted after reset starts a clean byte.

Configuration
REQ-026 SHALL support macro SHIFT_OUT_LSB_FIRST_EN: if defined, shift i_data bit 0 first and bit 7 last; if undefined, shift bit 7 first and bit 0 last. Timing is identical in both cases.

Verification
REQ-027 SHALL check: CLKDIV=2, i_load with i_data=0xA5 in IDLE -> o_sdata at the 8 sclk rising edges reads 1,0,1,0,0,1,0,1 (MSB-first build); o_busy high for 32 cycles.
REQ-028 SHALL check: same stimulus with SHIFT_OUT_LSB_FIRST_EN defined -> sequence 1,0,1,0,0,1,0,1 reversed; with 0x01 -> first bit 1 and the remaining seven bits 0.
REQ-029 SHALL check: i_load 0xFF accepted, then i_load 0x00 at cycle 5 -> the second load is ignored, eight 1 bits are shifted, and o_busy falls at cycle 32.
REQ-030 SHALL check: i_latch at cycle 10 of a shift with CLKDIV=2 -> o_rclk is high 2 cycles, starting right after the 8th sclk high phase; o_busy stays high continuously until the rclk pulse ends.
REQ-031 SHALL check: i_rst at cycle 9 mid-shift -> all outputs are 0 on the next cycle, with no later rclk pulse; a following i_load 0x3C shifts correctly.
REQ-032 SHALL check: CLKDIV=1, back-to-back i_load on the cycle o_busy falls -> the next byte is accepted with 16-cycle busy and no lost bits.
